// File: rtl/seq_target_ctrl.sv
// seq_target_ctrl: programmable sensor-sequence targeting controller.
//
// Detects PREAMBLE_LEN consecutive preamble samples, then gate A, then
// gate B, then HITS hit samples within a WINDOW-cycle hunt window. On
// detection it raises fire_req and holds it until the actuator
// acknowledges (or an abort arrives). An acknowledged fire bumps a
// saturating counter and enters a COOLDOWN-cycle lockout.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              detector enable (low forces IDLE except in cooldown)
//   sensor_in           one sensor sample per cycle
//   *_code              runtime-programmable codes, held stable while busy
//   fire_ack            actuator acknowledge, only honoured in FIRE
//   fire_req            fire request, held until ack/abort
//   busy                state != IDLE
//   timeout, aborted    single-cycle status pulses
//   fire_count          acknowledged fires, saturating
//   state_o             current FSM state (debug)
//
// Handshake: fire_req is a level held high from the detection edge; the
// transfer completes on the first clock edge where fire_req && fire_ack,
// after which fire_req drops. fire_ack while fire_req is low is ignored.
module seq_target_ctrl #(
  parameter int SW           = 3,
  parameter int PREAMBLE_LEN = 2,
  parameter int HITS         = 2,
  parameter int WINDOW       = 16,
  parameter int COOLDOWN     = 4,
  parameter int FCW          = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [SW-1:0] sensor_in,
  input  logic [SW-1:0] preamble_code,
  input  logic [SW-1:0] gate_a_code,
  input  logic [SW-1:0] gate_b_code,
  input  logic [SW-1:0] hit_code,
  input  logic [SW-1:0] abort_code,
  input  logic          fire_ack,
  output logic          fire_req,
  output logic          busy,
  output logic          timeout,
  output logic          aborted,
  output logic [FCW-1:0] fire_count,
  output logic [2:0]    state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_GATE_A   = 3'd2,
    S_GATE_B   = 3'd3,
    S_HUNT     = 3'd4,
    S_FIRE     = 3'd5,
    S_COOLDOWN = 3'd6
  } state_e;

  localparam int PW = $clog2(PREAMBLE_LEN) + 1;
  localparam int HW = $clog2(HITS) + 1;
  localparam int WW = $clog2(WINDOW) + 1;
  localparam int CW = $clog2(COOLDOWN + 1) + 1;
  // Last cooldown count; only reachable when COOLDOWN > 0.
  localparam int CD_LAST = (COOLDOWN > 0) ? COOLDOWN - 1 : 0;

  state_e         state_q, state_d;
  logic [PW-1:0]  pre_cnt_q, pre_cnt_d;
  logic [HW-1:0]  hit_cnt_q, hit_cnt_d;
  logic [WW-1:0]  win_cnt_q, win_cnt_d;
  logic [CW-1:0]  cd_cnt_q, cd_cnt_d;
  logic           fire_req_q, fire_req_d;
  logic           busy_q, busy_d;
  logic           timeout_q, timeout_d;
  logic           aborted_q, aborted_d;
  logic [FCW-1:0] fire_count_q, fire_count_d;
  logic           fire_inc;
  logic           is_abort;

  assign is_abort = (sensor_in == abort_code);

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pre_cnt_q    <= '0;
      hit_cnt_q    <= '0;
      win_cnt_q    <= '0;
      cd_cnt_q     <= '0;
      fire_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      aborted_q    <= 1'b0;
      fire_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      win_cnt_q    <= win_cnt_d;
      cd_cnt_q     <= cd_cnt_d;
      fire_req_q   <= fire_req_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      aborted_q    <= aborted_d;
      fire_count_q <= fire_count_d;
    end
  end

  // Next-state logic. Priority: enable low, then abort, then normal flow.
  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    hit_cnt_d = hit_cnt_q;
    win_cnt_d = win_cnt_q;
    cd_cnt_d  = cd_cnt_q;
    timeout_d = 1'b0;
    aborted_d = 1'b0;
    fire_inc  = 1'b0;
    if (!enable && state_q != S_COOLDOWN) begin
      state_d   = S_IDLE;
      pre_cnt_d = '0;
      hit_cnt_d = '0;
      win_cnt_d = '0;
    end else if (is_abort && state_q inside {S_PREAMBLE, S_GATE_A, S_GATE_B,
                                             S_HUNT, S_FIRE}) begin
      state_d   = S_IDLE;
      pre_cnt_d = '0;
      hit_cnt_d = '0;
      win_cnt_d = '0;
      aborted_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (sensor_in == preamble_code) begin
            pre_cnt_d = PW'(1);
            state_d   = (PREAMBLE_LEN == 1) ? S_GATE_A : S_PREAMBLE;
          end
        end
        S_PREAMBLE: begin
          if (sensor_in == preamble_code) begin
            pre_cnt_d = pre_cnt_q + PW'(1);
            if (pre_cnt_q + PW'(1) == PW'(PREAMBLE_LEN)) state_d = S_GATE_A;
          end else begin
            // A mismatch never re-arms on the same sample.
            pre_cnt_d = '0;
            state_d   = S_IDLE;
          end
        end
        S_GATE_A: state_d = (sensor_in == gate_a_code) ? S_GATE_B : S_IDLE;
        S_GATE_B: begin
          if (sensor_in == gate_b_code) begin
            state_d   = S_HUNT;
            win_cnt_d = '0;
            hit_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_HUNT: begin
          win_cnt_d = win_cnt_q + WW'(1);
          // A completing hit on the last window cycle wins over timeout.
          if (sensor_in == hit_code && hit_cnt_q + HW'(1) == HW'(HITS)) begin
            hit_cnt_d = hit_cnt_q + HW'(1);
            state_d   = S_FIRE;
          end else if (win_cnt_q == WW'(WINDOW - 1)) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
          end else if (sensor_in == hit_code) begin
            hit_cnt_d = hit_cnt_q + HW'(1);
          end
        end
        S_FIRE: begin
          if (fire_ack) begin
            fire_inc = 1'b1;
            cd_cnt_d = '0;
            state_d  = (COOLDOWN == 0) ? S_IDLE : S_COOLDOWN;
          end
        end
        S_COOLDOWN: begin
          if (cd_cnt_q == CW'(CD_LAST)) state_d = S_IDLE;
          else                          cd_cnt_d = cd_cnt_q + CW'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: registered outputs follow the next state.
  always_comb begin
    fire_req_d   = (state_d == S_FIRE);
    busy_d       = (state_d != S_IDLE);
    fire_count_d = fire_count_q;
    if (fire_inc && fire_count_q != {FCW{1'b1}}) fire_count_d = fire_count_q + FCW'(1);
  end

  assign fire_req   = fire_req_q;
  assign busy       = busy_q;
  assign timeout    = timeout_q;
  assign aborted    = aborted_q;
  assign fire_count = fire_count_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_seq_target_ctrl.sv
module tb_seq_target_ctrl;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       enable;
  logic [2:0] sensor_in;
  logic [2:0] preamble_code, gate_a_code, gate_b_code, hit_code, abort_code;
  logic       fire_ack;

  logic       fire_req, busy, timeout, aborted;
  logic [7:0] fire_count;
  logic [2:0] state_o;

  logic       p1_fire_req, p1_busy, p1_timeout, p1_aborted;
  logic [7:0] p1_fire_count;
  logic [2:0] p1_state;

  logic       f2_fire_req, f2_busy, f2_timeout, f2_aborted;
  logic [1:0] f2_fire_count;
  logic [2:0] f2_state;

  int tests = 0;
  int fails = 0;

  seq_target_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sensor_in(sensor_in),
    .preamble_code(preamble_code), .gate_a_code(gate_a_code),
    .gate_b_code(gate_b_code), .hit_code(hit_code), .abort_code(abort_code),
    .fire_ack(fire_ack), .fire_req(fire_req), .busy(busy), .timeout(timeout),
    .aborted(aborted), .fire_count(fire_count), .state_o(state_o)
  );

  seq_target_ctrl #(.PREAMBLE_LEN(1)) dut_p1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sensor_in(sensor_in),
    .preamble_code(preamble_code), .gate_a_code(gate_a_code),
    .gate_b_code(gate_b_code), .hit_code(hit_code), .abort_code(abort_code),
    .fire_ack(fire_ack), .fire_req(p1_fire_req), .busy(p1_busy),
    .timeout(p1_timeout), .aborted(p1_aborted), .fire_count(p1_fire_count),
    .state_o(p1_state)
  );

  seq_target_ctrl #(.FCW(2)) dut_f2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sensor_in(sensor_in),
    .preamble_code(preamble_code), .gate_a_code(gate_a_code),
    .gate_b_code(gate_b_code), .hit_code(hit_code), .abort_code(abort_code),
    .fire_ack(fire_ack), .fire_req(f2_fire_req), .busy(f2_busy),
    .timeout(f2_timeout), .aborted(f2_aborted), .fire_count(f2_fire_count),
    .state_o(f2_state)
  );

  // Driver tasks: one sample per clock, outputs observed 1 time unit later.
  task automatic cyc(input logic [2:0] v);
    sensor_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    sensor_in = 3'b000;
    fire_ack  = 1'b0;
    enable    = 1'b1;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Preamble x2, gates, two consecutive hits: fire_req rises on the last edge.
  task automatic fire_seq();
    cyc(3'b111); cyc(3'b111); cyc(3'b001); cyc(3'b010); cyc(3'b100); cyc(3'b100);
  endtask

  task automatic test_reset();
    #2;
    tests++; if (fire_req !== 1'b0) begin $display("FAIL reset_fire_req got %b exp 0", fire_req); fails++; end
    tests++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %b exp 0", busy); fails++; end
    tests++; if (fire_count !== 8'd0) begin $display("FAIL reset_count got %0d exp 0", fire_count); fails++; end
    tests++; if (state_o !== 3'd0) begin $display("FAIL reset_state got %0d exp 0", state_o); fails++; end
    tests++; if (timeout !== 1'b0 || aborted !== 1'b0) begin $display("FAIL reset_pulses got %b%b exp 00", timeout, aborted); fails++; end
    apply_reset();
  endtask

  task automatic test_nominal();
    cyc(3'b111); cyc(3'b111); cyc(3'b001); cyc(3'b010); cyc(3'b100);
    tests++; if (state_o !== 3'd4 || busy !== 1'b1) begin $display("FAIL nom_hunt state %0d busy %b exp 4 1", state_o, busy); fails++; end
    cyc(3'b000);
    tests++; if (fire_req !== 1'b0) begin $display("FAIL nom_early_fire got %b exp 0", fire_req); fails++; end
    cyc(3'b100);
    tests++; if (fire_req !== 1'b1) begin $display("FAIL nom_fire got %b exp 1", fire_req); fails++; end
    cyc(3'b000); cyc(3'b000);
    tests++; if (fire_req !== 1'b1) begin $display("FAIL nom_fire_held got %b exp 1", fire_req); fails++; end
    fire_ack = 1'b1; cyc(3'b000); fire_ack = 1'b0;
    tests++; if (fire_req !== 1'b0 || fire_count !== 8'd1) begin $display("FAIL nom_ack req %b count %0d exp 0 1", fire_req, fire_count); fails++; end
    for (int i = 0; i < 4; i++) begin
      tests++; if (busy !== 1'b1) begin $display("FAIL nom_cooldown_%0d busy %b exp 1", i, busy); fails++; end
      cyc(3'b000);
    end
    tests++; if (busy !== 1'b0 || state_o !== 3'd0) begin $display("FAIL nom_idle busy %b state %0d exp 0 0", busy, state_o); fails++; end
  endtask

  task automatic test_abort();
    // Abort in HUNT.
    cyc(3'b111); cyc(3'b111); cyc(3'b001); cyc(3'b010); cyc(3'b100); cyc(3'b101);
    tests++; if (aborted !== 1'b1 || busy !== 1'b0) begin $display("FAIL abort_hunt aborted %b busy %b exp 1 0", aborted, busy); fails++; end
    cyc(3'b000);
    tests++; if (aborted !== 1'b0) begin $display("FAIL abort_pulse_width got %b exp 0", aborted); fails++; end
    // Abort in FIRE beats a simultaneous ack.
    fire_seq();
    tests++; if (fire_req !== 1'b1) begin $display("FAIL abort_fire_setup got %b exp 1", fire_req); fails++; end
    fire_ack = 1'b1; cyc(3'b101); fire_ack = 1'b0;
    tests++; if (fire_req !== 1'b0 || aborted !== 1'b1 || fire_count !== 8'd1) begin
      $display("FAIL abort_fire req %b ab %b count %0d exp 0 1 1", fire_req, aborted, fire_count); fails++; end
    cyc(3'b000);
    // Abort in COOLDOWN is ignored.
    fire_seq();
    fire_ack = 1'b1; cyc(3'b000); fire_ack = 1'b0;
    cyc(3'b101);
    tests++; if (aborted !== 1'b0 || busy !== 1'b1 || fire_count !== 8'd2) begin
      $display("FAIL abort_cooldown ab %b busy %b count %0d exp 0 1 2", aborted, busy, fire_count); fails++; end
    cyc(3'b000); cyc(3'b000);
    tests++; if (busy !== 1'b1) begin $display("FAIL abort_cooldown_len busy %b exp 1", busy); fails++; end
    cyc(3'b000);
    tests++; if (busy !== 1'b0) begin $display("FAIL abort_cooldown_end busy %b exp 0", busy); fails++; end
  endtask

  task automatic test_timeout();
    cyc(3'b111); cyc(3'b111); cyc(3'b001); cyc(3'b010);
    cyc(3'b100);
    for (int i = 0; i < 14; i++) cyc(3'b000);
    tests++; if (timeout !== 1'b0 || busy !== 1'b1) begin $display("FAIL tmo_early timeout %b busy %b exp 0 1", timeout, busy); fails++; end
    cyc(3'b000);
    tests++; if (timeout !== 1'b1 || busy !== 1'b0 || fire_req !== 1'b0) begin
      $display("FAIL tmo_pulse timeout %b busy %b req %b exp 1 0 0", timeout, busy, fire_req); fails++; end
    cyc(3'b000);
    tests++; if (timeout !== 1'b0) begin $display("FAIL tmo_pulse_width got %b exp 0", timeout); fails++; end
    // Completing hit on the last window cycle fires instead.
    cyc(3'b111); cyc(3'b111); cyc(3'b001); cyc(3'b010);
    cyc(3'b100);
    for (int i = 0; i < 14; i++) cyc(3'b000);
    cyc(3'b100);
    tests++; if (fire_req !== 1'b1 || timeout !== 1'b0) begin $display("FAIL tmo_last_hit req %b timeout %b exp 1 0", fire_req, timeout); fails++; end
    fire_ack = 1'b1; cyc(3'b000); fire_ack = 1'b0;
    tests++; if (fire_count !== 8'd3) begin $display("FAIL tmo_count got %0d exp 3", fire_count); fails++; end
    for (int i = 0; i < 4; i++) cyc(3'b000);
  endtask

  task automatic test_preamble();
    apply_reset();
    cyc(3'b111); cyc(3'b000);
    tests++; if (busy !== 1'b0 || state_o !== 3'd0) begin $display("FAIL pre_mismatch busy %b state %0d exp 0 0", busy, state_o); fails++; end
    cyc(3'b111); cyc(3'b111);
    tests++; if (state_o !== 3'd2) begin $display("FAIL pre_gate_a state %0d exp 2", state_o); fails++; end
    cyc(3'b111);
    tests++; if (state_o !== 3'd0) begin $display("FAIL pre_extra state %0d exp 0", state_o); fails++; end
    cyc(3'b001); cyc(3'b010); cyc(3'b100); cyc(3'b100);
    tests++; if (fire_req !== 1'b0 || busy !== 1'b0) begin $display("FAIL pre_no_fire req %b busy %b exp 0 0", fire_req, busy); fails++; end
    // Single-sample preamble build.
    cyc(3'b111); cyc(3'b001); cyc(3'b010); cyc(3'b100); cyc(3'b100);
    tests++; if (p1_fire_req !== 1'b1) begin $display("FAIL pre_len1_fire got %b exp 1", p1_fire_req); fails++; end
    tests++; if (fire_req !== 1'b0) begin $display("FAIL pre_len2_no_fire got %b exp 0", fire_req); fails++; end
    apply_reset();
  endtask

  task automatic test_enable();
    cyc(3'b111); cyc(3'b111); cyc(3'b001);
    tests++; if (state_o !== 3'd3) begin $display("FAIL en_gate_b state %0d exp 3", state_o); fails++; end
    enable = 1'b0; cyc(3'b010);
    tests++; if (state_o !== 3'd0 || busy !== 1'b0 || aborted !== 1'b0 || timeout !== 1'b0) begin
      $display("FAIL en_low state %0d busy %b ab %b tmo %b exp 0 0 0 0", state_o, busy, aborted, timeout); fails++; end
    cyc(3'b111);
    tests++; if (busy !== 1'b0) begin $display("FAIL en_low_idle busy %b exp 0", busy); fails++; end
    enable = 1'b1; cyc(3'b000);
  endtask

  task automatic test_async_reset();
    fire_seq();
    fire_ack = 1'b1; cyc(3'b000); fire_ack = 1'b0;
    for (int i = 0; i < 4; i++) cyc(3'b000);
    tests++; if (fire_count !== 8'd1) begin $display("FAIL rst_setup_count got %0d exp 1", fire_count); fails++; end
    fire_seq();
    tests++; if (fire_req !== 1'b1) begin $display("FAIL rst_setup_fire got %b exp 1", fire_req); fails++; end
    rst_n = 1'b0;
    #1;
    tests++; if (fire_req !== 1'b0 || fire_count !== 8'd0 || busy !== 1'b0) begin
      $display("FAIL rst_async req %b count %0d busy %b exp 0 0 0", fire_req, fire_count, busy); fails++; end
    #1;
    rst_n = 1'b1;
    cyc(3'b000);
  endtask

  task automatic test_saturation();
    int exp_cnt;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      fire_seq();
      tests++; if (f2_fire_req !== 1'b1) begin $display("FAIL sat_fire_%0d got %b exp 1", i, f2_fire_req); fails++; end
      fire_ack = 1'b1; cyc(3'b000); fire_ack = 1'b0;
      exp_cnt = (i + 1 > 3) ? 3 : i + 1;
      tests++; if (f2_fire_count !== 2'(exp_cnt)) begin $display("FAIL sat_count_%0d got %0d exp %0d", i, f2_fire_count, exp_cnt); fails++; end
      for (int j = 0; j < 4; j++) cyc(3'b000);
    end
  endtask

  initial begin
    enable        = 1'b1;
    sensor_in     = 3'b000;
    fire_ack      = 1'b0;
    preamble_code = 3'b111;
    gate_a_code   = 3'b001;
    gate_b_code   = 3'b010;
    hit_code      = 3'b100;
    abort_code    = 3'b101;
    test_reset();
    test_nominal();
    test_abort();
    test_timeout();
    test_preamble();
    test_enable();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
